// File: rtl/mux_pkg.sv
// mux_pkg: shared tag type and select-width helper for the pipelined selector.
`default_nettype none

package mux_pkg;

  localparam int TAG_IDX_W = 16;

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic                 scan;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_stage.sv
// mux_stage: one registered level of 2:1 muxes; the tag travels alongside the data.
`default_nettype none

module mux_stage
  import mux_pkg::*;
#(
  parameter int IN_WORDS = 2,
  parameter int W        = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hold,
  input  logic                       sel_bit,
  input  tag_t                       in_tag,
  input  logic [IN_WORDS*W-1:0]      in_data,
  output tag_t                       out_tag,
  output logic [(IN_WORDS/2)*W-1:0]  out_data
);

  localparam int OUT_WORDS = IN_WORDS / 2;

  logic [OUT_WORDS*W-1:0] nxt_data;

  always_comb begin
    nxt_data = '0;
    for (int j = 0; j < OUT_WORDS; j++) begin
      nxt_data[j*W +: W] = sel_bit ? in_data[(2*j+1)*W +: W] : in_data[2*j*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_tag  <= '0;
      out_data <= '0;
    end else if (!hold) begin
      out_tag  <= in_tag;
      out_data <= nxt_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_pipe_scan.sv
// mux_pipe_scan: pipelined N-way W-bit selector with valid/ready requests and auto-scan.
`default_nettype none

module mux_pipe_scan
  import mux_pkg::*;
#(
  parameter  int N   = 8,
  parameter  int W   = 1,
  localparam int SW  = sel_width(N),
  localparam int LAT = SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N*W-1:0] a,
  input  logic          scan,
  input  logic          s_valid,
  input  logic [SW-1:0] s_sel,
  output logic          s_ready,
  output logic [W-1:0]  y,
  output logic [SW-1:0] y_idx,
  output logic          y_err,
  output logic          y_valid,
  input  logic          y_ready,
  output logic          scan_done
);

  localparam int            LEAVES = 1 << LAT;
  localparam logic [SW-1:0] LAST   = SW'(N - 1);
  localparam logic [SW:0]   N_EXT  = (SW + 1)'(N);

  logic                  stall;
  logic [SW-1:0]         scan_idx;
  logic [SW-1:0]         issue_idx;
  tag_t                  issue_tag;
  tag_t                  last_tag;
  logic [LEAVES*W-1:0]   leaves;

  assign stall   = y_valid && !y_ready;
  assign s_ready = !stall;

  // Missing leaves of a non-power-of-two tree read as zero.
  always_comb begin
    leaves          = '0;
    leaves[N*W-1:0] = a;
  end

  always_comb begin
    issue_tag       = '0;
    issue_idx       = scan ? scan_idx : s_sel;
    issue_tag.valid = !stall && (scan || s_valid);
    issue_tag.err   = !scan && ({1'b0, s_sel} >= N_EXT);
    issue_tag.scan  = scan;
    issue_tag.idx   = TAG_IDX_W'(issue_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx <= '0;
    end else if (!scan) begin
      scan_idx <= '0;
    end else if (!stall) begin
      scan_idx <= (scan_idx == LAST) ? '0 : scan_idx + 1'b1;
    end
  end

  for (genvar i = 0; i < LAT; i++) begin : g_lvl
    localparam int IN_WORDS = LEAVES >> i;

    tag_t                          tin;
    tag_t                          tout;
    logic [IN_WORDS*W-1:0]         din;
    logic [(IN_WORDS/2)*W-1:0]     dout;

    if (i == 0) begin : g_first
      assign tin = issue_tag;
      assign din = leaves;
    end else begin : g_next
      assign tin = g_lvl[i-1].tout;
      assign din = g_lvl[i-1].dout;
    end

    mux_stage #(
      .IN_WORDS (IN_WORDS),
      .W        (W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .hold     (stall),
      .sel_bit  (tin.idx[i]),
      .in_tag   (tin),
      .in_data  (din),
      .out_tag  (tout),
      .out_data (dout)
    );
  end

  assign last_tag  = g_lvl[LAT-1].tout;
  assign y         = g_lvl[LAT-1].dout;
  assign y_valid   = last_tag.valid;
  assign y_err     = last_tag.err;
  assign y_idx     = last_tag.idx[SW-1:0];
  assign scan_done = y_valid && y_ready && last_tag.scan && (y_idx == LAST);

endmodule

`default_nettype wire

// File: tb/tb_mux_pipe_scan.sv
// tb_mux_pipe_scan: scoreboard bench over three configurations (N=8/W=4, N=5/W=8, N=1/W=4).
`default_nettype none

module tb_mux_pipe_scan;
  import mux_pkg::*;

  typedef struct {
    int y;
    int idx;
    bit err;
    bit done;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // DUT A: N=8, W=4
  logic        rst_a = 1'b1, scan_a = 1'b0, sv_a = 1'b0, yr_a = 1'b1;
  logic [31:0] a_a = 32'h76543210;
  logic [2:0]  sel_a = '0;
  logic        sr_a, ye_a, yv_a, sd_a;
  logic [3:0]  y_a;
  logic [2:0]  yi_a;

  // DUT B: N=5, W=8
  logic        rst_b = 1'b1, scan_b = 1'b0, sv_b = 1'b0, yr_b = 1'b1;
  logic [39:0] a_b = 40'hA4A3A2A1A0;
  logic [2:0]  sel_b = '0;
  logic        sr_b, ye_b, yv_b, sd_b;
  logic [7:0]  y_b;
  logic [2:0]  yi_b;

  // DUT C: N=1, W=4
  logic        rst_c = 1'b1, scan_c = 1'b0, sv_c = 1'b0, yr_c = 1'b1;
  logic [3:0]  a_c = 4'h9;
  logic [0:0]  sel_c = '0;
  logic        sr_c, ye_c, yv_c, sd_c;
  logic [3:0]  y_c;
  logic [0:0]  yi_c;

  mux_pipe_scan #(.N(8), .W(4)) u_a (
    .clk(clk), .rst(rst_a), .a(a_a), .scan(scan_a), .s_valid(sv_a), .s_sel(sel_a),
    .s_ready(sr_a), .y(y_a), .y_idx(yi_a), .y_err(ye_a), .y_valid(yv_a),
    .y_ready(yr_a), .scan_done(sd_a));

  mux_pipe_scan #(.N(5), .W(8)) u_b (
    .clk(clk), .rst(rst_b), .a(a_b), .scan(scan_b), .s_valid(sv_b), .s_sel(sel_b),
    .s_ready(sr_b), .y(y_b), .y_idx(yi_b), .y_err(ye_b), .y_valid(yv_b),
    .y_ready(yr_b), .scan_done(sd_b));

  mux_pipe_scan #(.N(1), .W(4)) u_c (
    .clk(clk), .rst(rst_c), .a(a_c), .scan(scan_c), .s_valid(sv_c), .s_sel(sel_c),
    .s_ready(sr_c), .y(y_c), .y_idx(yi_c), .y_err(ye_c), .y_valid(yv_c),
    .y_ready(yr_c), .scan_done(sd_c));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input int y, input int idx, input bit err,
                      input bit done, input int c);
    exp_t e;
    e.y = y; e.idx = idx; e.err = err; e.done = done; e.cyc = c;
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int id);
    case (id)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int id);
    case (id)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  // Output words are compared whenever valid, so a stalled word is re-checked each cycle.
  task automatic mon(input int id, input bit r, input bit v, input bit rd, input int y,
                     input int idx, input bit err, input bit done);
    exp_t e;
    if (r) return;
    if (!v) begin
      chk($sformatf("d%0d_done_idle", id), int'(done), 0);
    end else if (qsize(id) == 0) begin
      checks++;
      errors++;
      $display("FAIL d%0d_unexpected_out: got y=%0d idx=%0d, expected no output", id, y, idx);
    end else begin
      e = qfront(id);
      chk($sformatf("d%0d_y", id), y, e.y);
      chk($sformatf("d%0d_idx", id), idx, e.idx);
      chk($sformatf("d%0d_err", id), int'(err), int'(e.err));
      if (rd) begin
        chk($sformatf("d%0d_scan_done", id), int'(done), int'(e.done));
        if (e.cyc >= 0) chk($sformatf("d%0d_latency_cycle", id), cyc, e.cyc);
        qpop(id);
      end else begin
        chk($sformatf("d%0d_done_stalled", id), int'(done), 0);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst_a, yv_a, yr_a, int'(y_a), int'(yi_a), ye_a, sd_a);
    mon(1, rst_b, yv_b, yr_b, int'(y_b), int'(yi_b), ye_b, sd_b);
    mon(2, rst_c, yv_c, yr_c, int'(y_c), int'(yi_c), ye_c, sd_c);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nxt;
    int wait_cnt;

    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(negedge clk);
    chk("reset_y", int'(y_a), 0);
    chk("reset_idx", int'(yi_a), 0);
    chk("reset_err", int'(ye_a), 0);
    chk("reset_valid", int'(yv_a), 0);
    chk("reset_done", int'(sd_a), 0);
    chk("reset_s_ready", int'(sr_a), 1);

    // Single manual request, latency 3
    tick();
    sv_a = 1'b1; sel_a = 3'd5; push(0, 5, 5, 0, 0, cyc + 3);
    tick();
    sv_a = 1'b0;
    repeat (5) tick();

    // Back-to-back with the bus changing right after each issue
    sv_a = 1'b1; sel_a = 3'd0; a_a = 32'h76543210; push(0, 0, 0, 0, 0, cyc + 3);
    tick();
    sel_a = 3'd7; a_a = 32'h7FFFFFFF; push(0, 7, 7, 0, 0, cyc + 3);
    tick();
    sel_a = 3'd3; a_a = 32'hFFFF3FFF; push(0, 3, 3, 0, 0, cyc + 3);
    tick();
    sv_a = 1'b0; a_a = 32'hFFFFFFFF;
    repeat (5) tick();
    a_a = 32'h76543210;

    // Reset with three requests in flight
    sv_a = 1'b1; sel_a = 3'd1;
    tick();
    sel_a = 3'd2;
    tick();
    sel_a = 3'd4;
    tick();
    sv_a = 1'b0;
    q0.delete();
    rst_a = 1'b1;
    #1;
    chk("midrst_valid", int'(yv_a), 0);
    chk("midrst_y", int'(y_a), 0);
    chk("midrst_idx", int'(yi_a), 0);
    chk("midrst_err", int'(ye_a), 0);
    chk("midrst_done", int'(sd_a), 0);
    tick(); tick();
    rst_a = 1'b0;
    sv_a = 1'b1; sel_a = 3'd6; push(0, 6, 6, 0, 0, cyc + 3);
    tick();
    sv_a = 1'b0;
    repeat (5) tick();

    // Scan on N=5 with a 4-cycle backpressure window
    scan_b = 1'b1; nxt = 0;
    for (int i = 0; i < 12; i++) begin
      push(1, 8'hA0 + nxt, nxt, 0, nxt == 4, (i < 9) ? cyc + 3 : -1);
      nxt = (nxt + 1) % 5;
      tick();
    end
    yr_b = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("stall_s_ready", int'(sr_b), 0);
      tick();
    end
    yr_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(1, 8'hA0 + nxt, nxt, 0, nxt == 4, -1);
      nxt = (nxt + 1) % 5;
      tick();
    end

    // Back to manual mid-flight with an out-of-range select
    scan_b = 1'b0; sv_b = 1'b1; sel_b = 3'd6; push(1, 0, 6, 1, 0, cyc + 3);
    tick();
    sv_b = 1'b0;
    repeat (6) tick();

    // N=1: latency 1, index 1 out of range, scan repeats index 0
    sv_c = 1'b1; sel_c = 1'b0; push(2, 9, 0, 0, 0, cyc + 1);
    tick();
    sel_c = 1'b1; push(2, 0, 1, 1, 0, cyc + 1);
    tick();
    sv_c = 1'b0; scan_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(2, 9, 0, 0, 1, cyc + 1);
      tick();
    end
    scan_c = 1'b0;
    repeat (3) tick();

    wait_cnt = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && wait_cnt < 50) begin
      tick();
      wait_cnt++;
    end
    chk("drain_pending", q0.size() + q1.size() + q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
